// File: rtl/clock_pkg.sv
// Shared encodings for the alarm clock datapath: mode codes, alarm FSM
// states, field widths and limits, and the 24h -> 12h hour mapping.
package clock_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HR_W   = 5;
  localparam int MODE_W = 3;

  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
  localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN        = 3'd0,
    MODE_SET_HRS    = 3'd1,
    MODE_SET_MIN    = 3'd2,
    MODE_ZERO_SEC   = 3'd3,
    MODE_SET_AL_HRS = 3'd4,
    MODE_SET_AL_MIN = 3'd5,
    MODE_RUN_6      = 3'd6,
    MODE_RUN_7      = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    AL_IDLE    = 2'd0,
    AL_RINGING = 2'd1,
    AL_SNOOZE  = 2'd2
  } alarm_state_e;

  // Internal hour 0..23 to display hour 1..12 (midnight/noon show as 12).
  function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] hr);
    logic [HR_W-1:0] res;
    if (hr == 5'd0)       res = 5'd12;
    else if (hr > 5'd12)  res = hr - 5'd12;
    else                  res = hr;
    return res;
  endfunction

endpackage

// File: rtl/alarm_fsm.sv
// Alarm ring/snooze sequencer with down-counting ring and snooze timers.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------
// AL_IDLE    | not ringing; waits for an alarm hit in RUN while armed
// AL_RINGING | ring output high; ring timer counts 1 Hz ticks down
// AL_SNOOZE  | ring paused; snooze timer counts 1 Hz ticks down
module alarm_fsm
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 9
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic run_i,
  input  logic alarm_en_i,
  input  logic alarm_hit_i,
  input  logic snooze_i,
  output logic ring_o,
  output logic ring_next_o
);

  localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

  alarm_state_e state_q, state_d;
  logic [7:0]   ring_cnt_q, ring_cnt_d;

`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MINUTES * 60);
  logic [11:0] snz_cnt_q, snz_cnt_d;

  // Snooze timer register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) snz_cnt_q <= '0;
    else          snz_cnt_q <= snz_cnt_d;
  end
`else
  localparam int unused_snz_len = SNOOZE_MINUTES;
  logic unused_snooze;
  assign unused_snooze = snooze_i;
`endif

  // State and ring timer registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= AL_IDLE;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  // Next state; disarming wins over every other event.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    if (!alarm_en_i) begin
      state_d = AL_IDLE;
    end else begin
      case (state_q)
        AL_IDLE: begin
          if (run_i && alarm_hit_i) begin
            state_d    = AL_RINGING;
            ring_cnt_d = RING_LOAD;
          end
        end
        AL_RINGING: begin
          if (!run_i) begin
            state_d = AL_IDLE;
          end else if (tick_i && ring_cnt_q == 8'd1) begin
            state_d = AL_IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_i) begin
            state_d    = AL_SNOOZE;
            snz_cnt_d  = SNZ_LOAD;
            ring_cnt_d = RING_LOAD;
`endif
          end else if (tick_i) begin
            ring_cnt_d = ring_cnt_q - 8'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        AL_SNOOZE: begin
          if (tick_i) begin
            if (snz_cnt_q == 12'd1) begin
              state_d    = AL_RINGING;
              ring_cnt_d = RING_LOAD;
            end else begin
              snz_cnt_d = snz_cnt_q - 12'd1;
            end
          end
        end
`endif
        default: state_d = AL_IDLE;
      endcase
    end
  end

  assign ring_o      = (state_q == AL_RINGING);
  assign ring_next_o = (state_d == AL_RINGING);

endmodule

// File: rtl/alarm_clock_core.sv
// hh:mm:ss timekeeping with 12/24 h output, alarm registers, colon blink
// and a delayed display-update strobe. Optional snooze: ALARM_SNOOZE_EN.
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int HOUR_MODE_24   = 1,
  parameter int UPDATE_DELAY   = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 9
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_1hz_stb,
  input  logic       i_timeset_stb,
  input  logic [2:0] i_mode,
  input  logic       i_alarm_en,
  input  logic       i_snooze_stb,
  output logic [5:0] o_seconds,
  output logic [5:0] o_minutes,
  output logic [4:0] o_hours,
  output logic       o_pm,
  output logic [5:0] o_alarm_minutes,
  output logic [4:0] o_alarm_hours,
  output logic       o_alarm_ring,
  output logic       o_colon,
  output logic       o_update_stb
);

  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d, al_min_q, al_min_d;
  logic [HR_W-1:0]  hr_q, hr_d, al_hr_q, al_hr_d;
  logic             colon_q, colon_d;
  logic             was_run_q;
  logic [UPDATE_DELAY-1:0] dly_q, dly_d;

  mode_e mode;
  logic  run;
  logic  alarm_hit;
  logic  ring_next;
  logic  upd_event;

  assign mode = mode_e'(i_mode);
  assign run  = (mode == MODE_RUN) || (mode == MODE_RUN_6) || (mode == MODE_RUN_7);

  // Time and alarm field next values; only the strobe owned by the mode acts.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    case (mode)
      MODE_SET_HRS:    if (i_timeset_stb) hr_d = (hr_q == MAX_HR) ? '0 : hr_q + 5'd1;
      MODE_SET_MIN:    if (i_timeset_stb) min_d = (min_q == MAX_MIN) ? '0 : min_q + 6'd1;
      MODE_ZERO_SEC:   sec_d = '0;
      MODE_SET_AL_HRS: if (i_timeset_stb) al_hr_d = (al_hr_q == MAX_HR) ? '0 : al_hr_q + 5'd1;
      MODE_SET_AL_MIN: if (i_timeset_stb) al_min_d = (al_min_q == MAX_MIN) ? '0 : al_min_q + 6'd1;
      default: begin
        if (i_1hz_stb) begin
          if (sec_q == MAX_SEC) begin
            sec_d = '0;
            if (min_q == MAX_MIN) begin
              min_d = '0;
              hr_d  = (hr_q == MAX_HR) ? '0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
    endcase
  end

  // Alarm matches on the post-tick time so hh:mm:00 rings on the tick that reaches it.
  assign alarm_hit = run && i_1hz_stb && (sec_d == '0) &&
                     (min_d == al_min_q) && (hr_d == al_hr_q);

  // Colon blinks in RUN, is solid in set modes and restarts dark on re-entering RUN.
  always_comb begin
    colon_d = colon_q;
    if (!run)            colon_d = 1'b1;
    else if (!was_run_q) colon_d = 1'b0;
    else if (i_1hz_stb)  colon_d = ~colon_q;
  end

  assign upd_event = (sec_d != sec_q) || (min_d != min_q) || (hr_d != hr_q) ||
                     (al_min_d != al_min_q) || (al_hr_d != al_hr_q) ||
                     (ring_next != o_alarm_ring);

  if (UPDATE_DELAY == 1) begin : g_dly1
    assign dly_d = upd_event;
  end else begin : g_dlyn
    assign dly_d = {dly_q[UPDATE_DELAY-2:0], upd_event};
  end

  // Field, colon and update delay-line registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      al_min_q  <= '0;
      al_hr_q   <= '0;
      colon_q   <= 1'b0;
      was_run_q <= 1'b1;
      dly_q     <= '0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      al_min_q  <= al_min_d;
      al_hr_q   <= al_hr_d;
      colon_q   <= colon_d;
      was_run_q <= run;
      dly_q     <= dly_d;
    end
  end

  alarm_fsm #(
    .RING_SECONDS  (RING_SECONDS),
    .SNOOZE_MINUTES(SNOOZE_MINUTES)
  ) u_alarm_fsm (
    .clk_i      (i_clk),
    .rst_n_i    (i_reset_n),
    .tick_i     (i_1hz_stb),
    .run_i      (run),
    .alarm_en_i (i_alarm_en),
    .alarm_hit_i(alarm_hit),
    .snooze_i   (i_snooze_stb),
    .ring_o     (o_alarm_ring),
    .ring_next_o(ring_next)
  );

  assign o_seconds       = sec_q;
  assign o_minutes       = min_q;
  assign o_hours         = (HOUR_MODE_24 != 0) ? hr_q : to_12h(hr_q);
  assign o_pm            = (hr_q >= 5'd12);
  assign o_alarm_minutes = al_min_q;
  assign o_alarm_hours   = (HOUR_MODE_24 != 0) ? al_hr_q : to_12h(al_hr_q);
  assign o_colon         = colon_q;
  assign o_update_stb    = dly_q[UPDATE_DELAY-1];

endmodule
